tone_gen_multi: RTL and testbench
=================================

TONE_GEN_MULTI -- requirements
Module: tone_gen_multi

Interface
REQ-001 SHALL have parameter WIDTH_COUNTER, default 10, the width of each channel's divider and counter.
REQ-002 SHALL have parameter NUM_CH, default 4, the number of independent tone channels (1..16).
REQ-003 SHALL have parameter GLIDE_PERIOD, default 16, the clock cycles per glide step (>=1; used only with TONE_GEN_GLIDE_EN).
REQ-004 SHALL have port clk  input  1  the sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port div  input  NUM_CH*WIDTH_COUNTER  packed per-channel half-period; channel i uses bits [i*WIDTH_COUNTER +: WIDTH_COUNTER].
REQ-007 SHALL have port en  input  NUM_CH  per-channel enable.
REQ-008 SHALL have port tone  output  NUM_CH  per-channel square wave, registered.
REQ-009 SHALL have port mix  output  $clog2(NUM_CH+1)  registered count of channels whose tone bit is high.

Function
REQ-010 Each channel SHALL keep a counter count_i and an effective divider cur_i, both WIDTH_COUNTER bits wide.
REQ-011 Each channel SHALL register div_i into div_hold_i every cycle.
REQ-012 Channel priority per cycle SHALL be: (1) en_i=0; (2) target div_i=0; (3) divider change; (4) terminal count; (5) increment.
REQ-013 With en_i=0, the channel SHALL set tone_i<=0 and count_i<=1 synchronously.
REQ-014 With div_i=0, the channel SHALL be silent: tone_i<=0, count_i<=1 and cur_i<=0.
REQ-015 Terminal count: when count_i>=cur_i and cur_i!=0, the channel SHALL toggle tone_i and set count_i<=1.
REQ-016 Otherwise, count_i SHALL increment by 1 and wrap modulo 2^WIDTH_COUNTER.
REQ-017 In steady state, tone_i SHALL have period 2*cur_i cycles and 50% duty.
REQ-018 After en_i rises with a stable nonzero div, the first tone_i rise SHALL occur on the cur_i-th rising edge with en_i high.
REQ-019 mix SHALL equal the popcount of tone, registered, with 1 cycle of latency after tone.
REQ-020 Channels SHALL be fully independent; simultaneous toggles on all channels are legal, and mix then reflects all of them on the next cycle.
REQ-021 Asserting en_i=0 mid-period SHALL abort the period immediately, with no partial toggle.

Reset
REQ-022 While rst_n=0, all count_i SHALL be 0, cur_i 0, div_hold_i 0, tone 0, mix 0, and the glide prescaler 0.
REQ-023 Reset assertion SHALL take effect asynchronously; deassertion SHALL be sampled synchronously on clk.
REQ-024 On the first cycle after reset, count_i SHALL take 1 via REQ-013, REQ-014, REQ-015 or REQ-016.

Configuration
REQ-025 Macro TONE_GEN_GLIDE_EN SHALL select glide (portamento) behaviour.
REQ-026 Without TONE_GEN_GLIDE_EN: cur_i SHALL equal div_i combinationally, and div_i!=div_hold_i SHALL force count_i<=1 with tone_i held (phase restart).
REQ-027 With TONE_GEN_GLIDE_EN: no phase restart SHALL occur.
REQ-028 With TONE_GEN_GLIDE_EN: if cur_i=0 and div_i!=0, cur_i SHALL load div_i directly.
REQ-029 With TONE_GEN_GLIDE_EN: otherwise, when the shared prescaler wraps (every GLIDE_PERIOD cycles), each cur_i!=div_i SHALL step by exactly 1 toward div_i.
REQ-030 With TONE_GEN_GLIDE_EN: terminal count SHALL use count_i>=cur_i, so that a shrinking cur_i never skips a toggle.
REQ-031 Without the macro, the glide prescaler and cur_i registers SHALL not be instantiated.

Verification
REQ-032 Scenario: NUM_CH=4, div0=5, en=4'b0001 after reset -> tone[0] rises at the 5th enabled edge, period 10 cycles, and mix alternates 0/1 one cycle after tone[0].
REQ-033 Scenario: channels div={3,4,6,12}, all enabled, run 24 cycles -> at the cycle-24 alignment all tones toggle together, and mix moves 4->0 or 0->4 one cycle later.
REQ-034 Scenario, no macro: div0 changes 8->3 mid-period at count 5 -> count restarts at 1, tone holds, and the next toggle is 3 cycles after the change is registered.
REQ-035 Scenario: drop en0 while tone0=1 -> tone0=0 next edge; set div1=0 -> tone1=0 and stays low.
REQ-036 Scenario: assert rst_n=0 asynchronously between edges with tones active -> tone=0 and mix=0 immediately, without waiting for clk.
REQ-037 Scenario, TONE_GEN_GLIDE_EN with GLIDE_PERIOD=4: div0 changes 10->6 -> cur0 reaches 6 after 4 prescaler wraps (16 cycles), with no missed toggle.

Source files
------------

// File: rtl/tone_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen_multi
//  Description : NUM_CH independent square-wave tone generators with a
//                registered popcount mix output. Each channel toggles its
//                tone every cur_i cycles (half-period = cur_i).
//                Optional macro TONE_GEN_GLIDE_EN: the effective divider
//                glides one step per GLIDE_PERIOD cycles toward the target
//                instead of restarting the phase on a divider change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_gen_multi #(
   parameter int WIDTH_COUNTER = 10,
   parameter int NUM_CH        = 4,
   parameter int GLIDE_PERIOD  = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CH*WIDTH_COUNTER-1:0]   div,
   input  logic [NUM_CH-1:0]                 en,
   output logic [NUM_CH-1:0]                 tone,
   output logic [$clog2(NUM_CH+1)-1:0]       mix
);

   localparam int C_MIX_W = $clog2(NUM_CH+1);

   // An illegal glide period produces an extra, empty block that stands out
   // in elaboration hierarchy reports.
   if (GLIDE_PERIOD < 1) begin : g_glide_period_illegal
   end

`ifdef TONE_GEN_GLIDE_EN
   localparam int C_PRE_W = (GLIDE_PERIOD > 1) ? $clog2(GLIDE_PERIOD) : 1;

   logic [C_PRE_W-1:0] r_prescale;
   logic               w_glide_tick;

   assign w_glide_tick = (r_prescale == C_PRE_W'(GLIDE_PERIOD - 1));

   // Shared prescaler: wraps every GLIDE_PERIOD cycles to pace glide steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescale <= '0;
      end else if (w_glide_tick) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + 1'b1;
      end
   end
`endif

   logic [NUM_CH-1:0] w_tone;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [WIDTH_COUNTER-1:0] w_div;
      logic [WIDTH_COUNTER-1:0] w_cur;
      logic [WIDTH_COUNTER-1:0] r_count;
      logic [WIDTH_COUNTER-1:0] r_div_hold;
      logic                     r_tone;
      logic                     w_restart;

      assign w_div     = div[i*WIDTH_COUNTER +: WIDTH_COUNTER];
      assign w_tone[i] = r_tone;

`ifdef TONE_GEN_GLIDE_EN
      logic [WIDTH_COUNTER-1:0] r_cur;

      // Effective divider: silence on zero target, jump from silence,
      // otherwise creep one step toward the target on each prescaler wrap.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cur <= '0;
         end else if (w_div == '0) begin
            r_cur <= '0;
         end else if (r_cur == '0) begin
            r_cur <= w_div;
         end else if (w_glide_tick && (r_cur != w_div)) begin
            r_cur <= (r_cur < w_div) ? r_cur + 1'b1 : r_cur - 1'b1;
         end
      end

      assign w_cur     = r_cur;
      assign w_restart = 1'b0;
`else
      assign w_cur     = w_div;
      assign w_restart = (w_div != r_div_hold);
`endif

      // Channel core: enable, silence, phase restart, terminal count, count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_count    <= '0;
            r_div_hold <= '0;
            r_tone     <= 1'b0;
         end else begin
            r_div_hold <= w_div;
            if (!en[i]) begin
               r_tone  <= 1'b0;
               r_count <= WIDTH_COUNTER'(1);
            end else if (w_div == '0) begin
               r_tone  <= 1'b0;
               r_count <= WIDTH_COUNTER'(1);
            end else if (w_restart) begin
               r_count <= WIDTH_COUNTER'(1);
            end else if ((w_cur != '0) && (r_count >= w_cur)) begin
               r_tone  <= ~r_tone;
               r_count <= WIDTH_COUNTER'(1);
            end else begin
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

   assign tone = w_tone;

   logic [C_MIX_W-1:0] w_pop;

   // Number of channels currently high.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_pop = w_pop + C_MIX_W'(w_tone[i]);
      end
   end

   // Mix is registered, one cycle behind the tone bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix <= '0;
      end else begin
         mix <= w_pop;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tone_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_gen_multi
//  Description : Directed self-checking bench for tone_gen_multi (default
//                build, 4 channels, 10-bit dividers).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_gen_multi;

   localparam int C_W  = 10;
   localparam int C_N  = 4;
   localparam int C_MW = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [C_N*C_W-1:0] div;
   logic [C_N-1:0]     en;
   logic [C_N-1:0]     tone;
   logic [C_MW-1:0]    mix;

   int n_vec = 0;
   int n_err = 0;
   int d [4];
   logic [3:0] exp_t;
   logic [3:0] prev_t;

   always #5 clk = ~clk;

   tone_gen_multi #(
      .WIDTH_COUNTER (C_W),
      .NUM_CH        (C_N),
      .GLIDE_PERIOD  (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .div   (div),
      .en    (en),
      .tone  (tone),
      .mix   (mix)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset state, single channel div=5 ----
      rst_n = 1'b0;
      div   = {30'd0, 10'd5};
      en    = 4'b0000;
      #12;
      check("reset_tone", 32'(tone), 32'd0);
      check("reset_mix",  32'(mix),  32'd0);
      rst_n = 1'b1;
      tick();
      en = 4'b0001;
      prev_t = 4'b0000;
      for (int k = 1; k <= 15; k++) begin
         tick();
         exp_t = {3'b000, ((k / 5) % 2) == 1};
         check("ch0_tone", 32'(tone), 32'(exp_t));
         check("ch0_mix",  32'(mix),  32'($countones(prev_t)));
         prev_t = exp_t;
      end

      // ---- phase restart on divider change 8 -> 3 at count 5 ----
      en = 4'b0000;
      div[0 +: C_W] = 10'd8;
      tick();
      check("restart_idle", 32'(tone), 32'd0);
      en = 4'b0001;
      for (int j = 1; j <= 4; j++) begin
         tick();
         check("restart_pre", 32'(tone), 32'd0);
      end
      div[0 +: C_W] = 10'd3;
      for (int j = 1; j <= 4; j++) begin
         tick();
         check("restart_post", 32'(tone), 32'(j == 4));
      end

      // ---- four channels {3,4,6,12}, then en0 drop and div1=0 ----
      d[0] = 3; d[1] = 4; d[2] = 6; d[3] = 12;
      en  = 4'b0000;
      div = {10'd12, 10'd6, 10'd4, 10'd3};
      tick();
      en = 4'b1111;
      prev_t = 4'b0000;
      for (int k = 1; k <= 40; k++) begin
         tick();
         for (int c = 0; c < 4; c++) begin
            exp_t[c] = ((k / d[c]) % 2) == 1;
         end
         if (k >= 29) begin
            exp_t[1:0] = 2'b00;
         end
         check("multi_tone", 32'(tone), 32'(exp_t));
         check("multi_mix",  32'(mix),  32'($countones(prev_t)));
         prev_t = exp_t;
         if (k == 28) begin
            en = 4'b1110;
            div[C_W +: C_W] = 10'd0;
         end
      end

      // ---- asynchronous reset between edges with tone3 high ----
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_tone", 32'(tone), 32'd0);
      check("async_rst_mix",  32'(mix),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
